aes_kexp_seq: RTL and testbench

Sequential AES key-expansion engine: captures the cipher key on a start pulse, generates one 32-bit schedule word per clock into an internal round-key buffer, then serves 128-bit round keys by index to the downstream add-round-key stage. It replaces the combinational expansion in front of the round datapath, trading 40–52 cycles of latency for a single shared SubWord path.

---
 rtl/aes_kexp_seq_pkg.sv | 16 +
 rtl/aes_subword.sv | 14 +
 rtl/aes_kexp_seq.sv | 145 ++++++++++++++
 tb/tb_aes_kexp_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_kexp_seq_pkg.sv
// Shared constants and types for the sequential AES key-expansion engine.
//   Nk, Nb       : default key length (32-bit words) and state columns
//   kexp_state_t : controller state encoding
//   rot_word     : RotWord helper (left rotate by one byte)
package aes_kexp_seq_pkg;

  localparam int Nk = 4;
  localparam int Nb = 4;

  typedef enum logic {IDLE, EXPAND} kexp_state_t;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
//   sbox : 256-entry S-box table
//   din  : input word
//   dout : byte-wise substituted word
module aes_subword (
  input  logic [0:255][7:0] sbox,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);

  assign dout = {sbox[din[31:24]], sbox[din[23:16]],
                 sbox[din[15:8]],  sbox[din[7:0]]};

endmodule

// File: rtl/aes_kexp_seq.sv
// Sequential AES key expansion: loads the cipher key on start, generates one
// schedule word per clock into a round-key buffer, then serves 128-bit round
// keys by index.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle expansion request (ignored while busy)
//   key       : cipher key, word 0 in MSBs
//   sbox/rcon : shared S-box table and round constants
//   rk_idx    : round index 0..NR
//   rk_inv    : (AES_KEXP_INV_EN only) serve round key NR-rk_idx
//   rk        : selected round key, 0 unless valid and rk_idx <= NR
//   busy      : expansion in progress
//   valid     : buffer holds a complete schedule
//   done      : one-cycle pulse at completion
// Build option: define AES_KEXP_INV_EN to add the rk_inv port.
module aes_kexp_seq
  import aes_kexp_seq_pkg::*;
#(
  parameter int NK = Nk,
  parameter int NB = Nb,
  parameter int NR = NK + 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [32*NK-1:0]  key,
  input  logic [0:255][7:0] sbox,
  input  logic [0:15][7:0]  rcon,
  input  logic [3:0]        rk_idx,
`ifdef AES_KEXP_INV_EN
  input  logic              rk_inv,
`endif
  output logic [127:0]      rk,
  output logic              busy,
  output logic              valid,
  output logic              done
);

  localparam int         NW      = NB * (NR + 1);
  localparam logic [5:0] FIRST   = 6'(NK);
  localparam logic [5:0] LAST    = 6'(NW - 1);
  localparam logic [2:0] REM_TOP = 3'(NK - 1);
  localparam logic [2:0] REM_SUB = 3'(NK - 4);

  kexp_state_t state_q, state_d;
  logic [5:0]  i_q;
  logic [2:0]  rem_q;   // (NK - i mod NK) mod NK: zero on multiples of NK
  logic [3:0]  rnd_q;   // i / NK, valid whenever rem_q == 0
  logic        valid_q, done_q;
  logic [31:0] w_q [NW];

  logic        load, step, last;
  logic [31:0] prev_w, back_w, sub_in, sub_out, t_w;
  logic [3:0]  sel;
  logic [5:0]  base;

  // State register and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      rem_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      if (load) begin
        i_q     <= FIRST;
        rem_q   <= '0;
        rnd_q   <= 4'd1;
        valid_q <= 1'b0;
      end else if (step) begin
        i_q   <= i_q + 6'd1;
        rem_q <= (rem_q == '0) ? REM_TOP : rem_q - 3'd1;
        if (rem_q == '0) rnd_q <= rnd_q + 4'd1;
        if (last) valid_q <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start)      state_d = EXPAND;
      EXPAND: if (i_q == LAST) state_d = IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    load  = (state_q == IDLE) && start;
    step  = (state_q == EXPAND);
    last  = step && (i_q == LAST);
    busy  = step;
    valid = valid_q;
    done  = done_q;
  end

  // Schedule word datapath; one SubWord instance serves both branches
  always_comb begin
    prev_w = w_q[i_q - 6'd1];
    back_w = w_q[i_q - FIRST];
    sub_in = (rem_q == '0) ? rot_word(prev_w) : prev_w;
  end

  aes_subword u_subword (
    .sbox (sbox),
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    t_w = prev_w;
    if (rem_q == '0)
      t_w = sub_out ^ {rcon[rnd_q], 24'h0};
    else if (NK > 6 && rem_q == REM_SUB)
      t_w = sub_out;
  end

  // Round-key buffer, intentionally not reset
  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned k = 0; k < NK; k++)
        w_q[k] <= key[32*(NK-1-k) +: 32];
    end else if (step) begin
      w_q[i_q] <= back_w ^ t_w;
    end
  end

  // Round-key read port
  always_comb begin
`ifdef AES_KEXP_INV_EN
    sel = rk_inv ? 4'(NR) - rk_idx : rk_idx;
`else
    sel = rk_idx;
`endif
    base = {sel, 2'b00};
    rk   = '0;
    if (valid_q && rk_idx <= 4'(NR))
      rk = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
  end

endmodule

// File: tb/tb_aes_kexp_seq.sv
// Self-checking bench for aes_kexp_seq with NK = 4, 6 and 8 instances.
module tb_aes_kexp_seq;

  localparam logic [255:0] KEY4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [0:255][7:0] sbox;
  logic [0:15][7:0]  rcon;
  logic              start_v  [3];
  logic [3:0]        rk_idx_v [3];
  logic [127:0]      rk_v     [3];
  logic              busy_v   [3];
  logic              valid_v  [3];
  logic              done_v   [3];
  logic [127:0]      key4;
  logic [191:0]      key6;
  logic [255:0]      key8;
`ifdef AES_KEXP_INV_EN
  logic              rk_inv_v [3];
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mw [60];

  aes_kexp_seq #(.NK(4)) u_k4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .key(key4), .sbox(sbox), .rcon(rcon),
    .rk_idx(rk_idx_v[0]),
`ifdef AES_KEXP_INV_EN
    .rk_inv(rk_inv_v[0]),
`endif
    .rk(rk_v[0]), .busy(busy_v[0]), .valid(valid_v[0]), .done(done_v[0]));

  aes_kexp_seq #(.NK(6)) u_k6 (
    .clk(clk), .rst(rst), .start(start_v[1]), .key(key6), .sbox(sbox), .rcon(rcon),
    .rk_idx(rk_idx_v[1]),
`ifdef AES_KEXP_INV_EN
    .rk_inv(rk_inv_v[1]),
`endif
    .rk(rk_v[1]), .busy(busy_v[1]), .valid(valid_v[1]), .done(done_v[1]));

  aes_kexp_seq #(.NK(8)) u_k8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .key(key8), .sbox(sbox), .rcon(rcon),
    .rk_idx(rk_idx_v[2]),
`ifdef AES_KEXP_INV_EN
    .rk_inv(rk_inv_v[2]),
`endif
    .rk(rk_v[2]), .busy(busy_v[2]), .valid(valid_v[2]), .done(done_v[2]));

  // GF(2^8) arithmetic for building the S-box from its definition
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] sbox_val(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < 254; k++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rc(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < j; k++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Reference key schedule straight from the expansion rules
  task automatic model(input int nk, input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input int inst, input logic [255:0] k);
    case (inst)
      0:       key4 = k[255:128];
      1:       key6 = k[255:64];
      default: key8 = k;
    endcase
  endtask

  task automatic read_rk(input int inst, input int idx, output logic [127:0] v);
    @(negedge clk);
    rk_idx_v[inst] = 4'(idx);
    #1 v = rk_v[inst];
  endtask

  task automatic check_all(input int inst, input int nk);
    int nr;
    logic [127:0] v, exp;
    nr = nk + 6;
    for (int r = 0; r < 16; r++) begin
      read_rk(inst, r, v);
      exp = '0;
      if (r <= nr) exp = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      check($sformatf("rk%0d_nk%0d", r, nk), v, exp);
    end
`ifdef AES_KEXP_INV_EN
    rk_inv_v[inst] = 1'b1;
    for (int r = 0; r < 16; r++) begin
      read_rk(inst, r, v);
      exp = '0;
      if (r <= nr) exp = {mw[4*(nr-r)], mw[4*(nr-r)+1], mw[4*(nr-r)+2], mw[4*(nr-r)+3]};
      check($sformatf("rkinv%0d_nk%0d", r, nk), v, exp);
    end
    rk_inv_v[inst] = 1'b0;
`endif
  endtask

  // Start an expansion, optionally re-pulsing start at cycle 10 with a stray key
  task automatic run_expand(input int inst, input logic [255:0] k, input bit poke);
    int cyc, nk;
    nk = 4 + 2*inst;
    set_key(inst, k);
    model(nk, k);
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1 start_v[inst] = 1'b0;
    check("busy_after_start", 128'(busy_v[inst]), 128'd1);
    check("valid_after_start", 128'(valid_v[inst]), 128'd0);
    cyc = 0;
    while (done_v[inst] !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
      if (poke && cyc == 10) begin
        start_v[inst] = 1'b1;
        set_key(inst, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      end else begin
        start_v[inst] = 1'b0;
      end
    end
    check($sformatf("latency_nk%0d", nk), 128'(cyc), 128'(4*(nk+7) - nk));
    check("valid_with_done", 128'(valid_v[inst]), 128'd1);
    check("busy_cleared", 128'(busy_v[inst]), 128'd0);
    @(posedge clk);
    #1 check("done_one_cycle", 128'(done_v[inst]), 128'd0);
    check("valid_held", 128'(valid_v[inst]), 128'd1);
    check_all(inst, nk);
  endtask

  initial begin
    logic [127:0] v;
    int done_seen;
    rst = 1'b1;
    key4 = '0; key6 = '0; key8 = '0;
    for (int n = 0; n < 3; n++) begin
      start_v[n] = 1'b0;
      rk_idx_v[n] = '0;
`ifdef AES_KEXP_INV_EN
      rk_inv_v[n] = 1'b0;
`endif
    end
    for (int x = 0; x < 256; x++) sbox[x] = sbox_val(8'(x));
    rcon[0] = 8'h8d;
    for (int j = 1; j < 16; j++) rcon[j] = (j == 1) ? 8'h01 : xtime(rcon[j-1]);

    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      check("reset_busy", 128'(busy_v[n]), 128'd0);
      check("reset_valid", 128'(valid_v[n]), 128'd0);
      check("reset_done", 128'(done_v[n]), 128'd0);
      check("reset_rk", rk_v[n], 128'd0);
    end
    @(negedge clk) rst = 1'b0;

    // FIPS-197 vectors
    run_expand(0, KEY4, 1'b0);
    read_rk(0, 1, v);  check("fips_nk4_w4", 128'(v[127:96]), 128'h a0fafe17);
    read_rk(0, 10, v); check("fips_nk4_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_expand(1, KEY6, 1'b0);
    read_rk(1, 1, v);  check("fips_nk6_w6", 128'(v[63:32]), 128'h fe0c91f7);
    read_rk(1, 12, v); check("fips_nk6_w51", 128'(v[31:0]), 128'h01002202);
    run_expand(2, KEY8, 1'b0);
    read_rk(2, 2, v);  check("fips_nk8_w8", 128'(v[127:96]), 128'h9ba35411);
    read_rk(2, 14, v); check("fips_nk8_w59", 128'(v[31:0]), 128'h706c631e);

    // Start while busy is ignored; restart while valid uses the new key
    run_expand(0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b1);
    run_expand(0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0);

    // Reset mid-expansion
    set_key(0, KEY4);
    @(negedge clk) start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 128'(busy_v[0]), 128'd0);
    check("rst_valid", 128'(valid_v[0]), 128'd0);
    check("rst_done", 128'(done_v[0]), 128'd0);
    check("rst_rk_nk8", rk_v[2], 128'd0);
    check("rst_valid_nk8", 128'(valid_v[2]), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1 if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) done_seen++;
    end
    check("no_done_after_rst", 128'(done_seen), 128'd0);
    check("valid_after_rst", 128'(valid_v[0]), 128'd0);

    // Random keys on every key length
    for (int it = 0; it < 2; it++)
      for (int n = 0; n < 3; n++)
        run_expand(n, {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
